// File: rtl/src_ring_buf.sv
// rtl/src_ring_buf.sv - multi-bank fp32-to-bf16 source ring buffer with commit/release handoff
module src_ring_buf #(
    parameter int BANKS = 2,
    parameter int DEPTH = 512,
    parameter int LANES = 2,
    parameter int RND   = 0,
    localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int IW   = $clog2(DEPTH * LANES),
    localparam int LW   = $clog2(LANES),
    localparam int LWS  = (LW > 0) ? LW : 1,
    localparam int WW   = 16 * LANES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               src_v,
    input  logic [AW-1:0]      src_a,
    input  logic [32*LANES-1:0] src_d,
    input  logic               src_last,
    output logic               src_rdy,
    input  logic               exec,
    input  logic [IW-1:0]      ia,
    input  logic               rd_done,
    output logic               rd_rdy,
    output logic [15:0]        d,
    output logic               d_v,
    output logic [BW:0]        fill_cnt,
    output logic               err_ovf,
    output logic               err_udf
);

    // fp32 -> bf16; NaN payload is kept non-zero so a NaN never collapses to Inf
    function automatic logic [15:0] cvt(input logic [31:0] f);
        logic [15:0] r;
        r = f[31:16];
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 23'd0) r[6] = 1'b1;
        end else if (RND != 0) begin
            r = r + {15'd0, f[15] & (f[16] | (|f[14:0]))};
        end
        return r;
    endfunction

    logic [BW-1:0] wr_bank_q, wr_bank_d;
    logic [BW-1:0] rd_bank_q, rd_bank_d;
    logic [BW:0]   fill_q, fill_d;
    logic [15:0]   d_q, d_d;
    logic          d_v_q, d_v_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [WW-1:0] mem_q [BANKS][DEPTH];
    logic [WW-1:0] wdata;
    logic [WW-1:0] rd_word;
    logic [AW-1:0] word_idx;
    logic [LWS-1:0] lane_sel;
    logic          wr_acc, commit, rd_acc, rel;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign wdata[16*k +: 16] = cvt(src_d[32*k +: 32]);
    end

    // Flow-control flags come only from the registered fill count
    assign src_rdy  = (fill_q != (BW+1)'(BANKS));
    assign rd_rdy   = (fill_q != '0);
    assign fill_cnt = fill_q;
    assign d        = d_q;
    assign d_v      = d_v_q;
    assign err_ovf  = ovf_q;
    assign err_udf  = udf_q;

    assign wr_acc   = src_v & src_rdy;
    assign commit   = wr_acc & src_last;
    assign rd_acc   = exec & rd_rdy;
    assign rel      = rd_done & rd_rdy;
    assign word_idx = ia[IW-1:LW];
    assign lane_sel = LWS'(ia) & LWS'(LANES - 1);
    assign rd_word  = mem_q[rd_bank_q][word_idx];

    // Bank storage: write into the writer's bank, never reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_bank_q][src_a] <= wdata;
    end

    // Pointer, fill, read-output and sticky-error next state
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        fill_d    = fill_q;
        d_d       = d_q;
        d_v_d     = rd_acc;
        if (commit) wr_bank_d = wr_bank_q + 1'b1;
        if (rel)    rd_bank_d = rd_bank_q + 1'b1;
        case ({commit, rel})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        if (rd_acc) d_d = rd_word[16*lane_sel +: 16];
        ovf_d = ovf_q | (src_v & ~src_rdy);
        udf_d = udf_q | ((exec | rd_done) & ~rd_rdy);
    end

    // Control state register; a reset drops every committed bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            fill_q    <= '0;
            d_q       <= 16'h0;
            d_v_q     <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            fill_q    <= fill_d;
            d_q       <= d_d;
            d_v_q     <= d_v_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

endmodule

// File: tb/tb_src_ring_buf.sv
// tb/tb_src_ring_buf.sv - self-checking bench for src_ring_buf
module tb_src_ring_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic        a_rst_n, a_src_v, a_src_last, a_exec, a_rd_done;
    logic [8:0]  a_src_a;
    logic [63:0] a_src_d;
    logic [9:0]  a_ia;
    logic        a_src_rdy, a_rd_rdy, a_d_v, a_ovf, a_udf;
    logic [15:0] a_d;
    logic [1:0]  a_fill;

    logic        b_rst_n, b_src_v, b_src_last, b_exec, b_rd_done;
    logic [3:0]  b_src_a;
    logic [63:0] b_src_d;
    logic [4:0]  b_ia;
    logic        b_src_rdy, b_rd_rdy, b_d_v, b_ovf, b_udf;
    logic [15:0] b_d;
    logic [2:0]  b_fill;

    src_ring_buf #(.BANKS(2), .DEPTH(512), .LANES(2), .RND(0)) u_a (
        .clk(clk), .rst_n(a_rst_n), .src_v(a_src_v), .src_a(a_src_a), .src_d(a_src_d),
        .src_last(a_src_last), .src_rdy(a_src_rdy), .exec(a_exec), .ia(a_ia),
        .rd_done(a_rd_done), .rd_rdy(a_rd_rdy), .d(a_d), .d_v(a_d_v),
        .fill_cnt(a_fill), .err_ovf(a_ovf), .err_udf(a_udf));

    src_ring_buf #(.BANKS(4), .DEPTH(16), .LANES(2), .RND(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .src_v(b_src_v), .src_a(b_src_a), .src_d(b_src_d),
        .src_last(b_src_last), .src_rdy(b_src_rdy), .exec(b_exec), .ia(b_ia),
        .rd_done(b_rd_done), .rd_rdy(b_rd_rdy), .d(b_d), .d_v(b_d_v),
        .fill_cnt(b_fill), .err_ovf(b_ovf), .err_udf(b_udf));

    // Reference model: per-bank expected operands plus ring pointers as plain integers
    logic [15:0] ma [2][1024];
    logic [15:0] mb [4][32];
    int a_wb = 0, a_rb = 0, a_fc = 0;
    int b_wb = 0, b_rb = 0, b_fc = 0;
    int ad1[8], ad2[8], ad3[4];

    function automatic logic [15:0] ref_bf16(input logic [31:0] f, input int rnd);
        longint unsigned v, hi, lo, ex, man;
        v   = longint'(f);
        hi  = v / 65536;
        lo  = v % 65536;
        ex  = (v / 8388608) % 256;
        man = v % 8388608;
        if (ex == 255) return (man != 0) ? 16'(hi | 64) : 16'(hi);
        if (rnd != 0 && (lo > 32768 || (lo == 32768 && hi % 2 == 1))) hi = hi + 1;
        return 16'(hi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input int adr, input logic [63:0] dat, input bit last);
        a_src_v = 1'b1; a_src_a = adr[8:0]; a_src_d = dat; a_src_last = last;
        tick();
        a_src_v = 1'b0; a_src_last = 1'b0;
        if (a_fc < 2) begin
            ma[a_wb][2*adr]   = ref_bf16(dat[31:0], 0);
            ma[a_wb][2*adr+1] = ref_bf16(dat[63:32], 0);
            if (last) begin a_wb = (a_wb + 1) % 2; a_fc++; end
        end
    endtask

    task automatic rd_a(input int op);
        a_exec = 1'b1; a_ia = op[9:0];
        tick();
        a_exec = 1'b0;
        chk("a_dv", a_d_v, 1);
        chk("a_d", a_d, ma[a_rb][op]);
    endtask

    task automatic rel_a();
        a_rd_done = 1'b1;
        tick();
        a_rd_done = 1'b0;
        if (a_fc > 0) begin a_rb = (a_rb + 1) % 2; a_fc--; end
        chk("a_fill_rel", a_fill, a_fc);
    endtask

    task automatic wr_b(input int adr, input logic [63:0] dat, input bit last);
        b_src_v = 1'b1; b_src_a = adr[3:0]; b_src_d = dat; b_src_last = last;
        tick();
        b_src_v = 1'b0; b_src_last = 1'b0;
        if (b_fc < 4) begin
            mb[b_wb][2*adr]   = ref_bf16(dat[31:0], 1);
            mb[b_wb][2*adr+1] = ref_bf16(dat[63:32], 1);
            if (last) begin b_wb = (b_wb + 1) % 4; b_fc++; end
        end
    endtask

    task automatic rd_b(input int op);
        b_exec = 1'b1; b_ia = op[4:0];
        tick();
        b_exec = 1'b0;
        chk("b_dv", b_d_v, 1);
        chk("b_d", b_d, mb[b_rb][op]);
    endtask

    task automatic rel_b();
        b_rd_done = 1'b1;
        tick();
        b_rd_done = 1'b0;
        if (b_fc > 0) begin b_rb = (b_rb + 1) % 4; b_fc--; end
        chk("b_fill_rel", b_fill, b_fc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vec  [5];
        logic [15:0] vexp [5];
        logic [63:0] sd;
        vec  = '{32'h3F80_8000, 32'h3F81_8000, 32'h7F7F_FFFF, 32'h7F80_0001, 32'h3F80_8001};
        vexp = '{16'h3F80, 16'h3F82, 16'h7F80, 16'h7FC0, 16'h3F81};

        a_rst_n = 0; a_src_v = 0; a_src_last = 0; a_exec = 0; a_rd_done = 0;
        a_src_a = '0; a_src_d = '0; a_ia = '0;
        b_rst_n = 0; b_src_v = 0; b_src_last = 0; b_exec = 0; b_rd_done = 0;
        b_src_a = '0; b_src_d = '0; b_ia = '0;
        tick(); tick();
        chk("rst_fill", a_fill, 0);
        chk("rst_src_rdy", a_src_rdy, 1);
        chk("rst_rd_rdy", a_rd_rdy, 0);
        chk("rst_d", a_d, 0);
        chk("rst_dv", a_d_v, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        a_rst_n = 1; b_rst_n = 1;
        tick();

        // Underflow while empty
        a_exec = 1; a_rd_done = 1; a_ia = 10'd0;
        tick();
        a_exec = 0; a_rd_done = 0;
        chk("udf_flag", a_udf, 1);
        chk("udf_dv", a_d_v, 0);
        chk("udf_fill", a_fill, 0);
        chk("udf_d", a_d, 0);

        // Fill bank0 then drain it at one operand per cycle
        for (int i = 0; i < 512; i++) begin
            if (i == 511) chk("pre_commit_rd_rdy", a_rd_rdy, 0);
            wr_a(i, {32'h3F80_1234, 32'h4000_8000}, i == 511);
        end
        chk("fill_after_commit", a_fill, 1);
        chk("rd_rdy_after_commit", a_rd_rdy, 1);
        chk("src_rdy_one_bank", a_src_rdy, 1);
        for (int i = 0; i < 1024; i++) begin
            rd_a(i);
            if (i == 0) chk("ia0_const", a_d, 16'h4000);
            if (i == 1) chk("ia1_const", a_d, 16'h3F80);
        end
        tick();
        chk("dv_idle", a_d_v, 0);
        chk("d_hold", a_d, 16'h3F80);
        rel_a();
        chk("rd_rdy_drained", a_rd_rdy, 0);

        // Random banks up to full, rejected write, then drain both
        for (int i = 0; i < 8; i++) begin
            ad1[i] = $urandom_range(0, 511);
            wr_a(ad1[i], {$urandom, $urandom}, i == 7);
        end
        for (int i = 0; i < 8; i++) begin
            ad2[i] = $urandom_range(0, 511);
            wr_a(ad2[i], {$urandom, $urandom}, i == 7);
        end
        chk("full_fill", a_fill, 2);
        chk("full_src_rdy", a_src_rdy, 0);
        wr_a(ad1[0], {$urandom, $urandom}, 1'b1);
        chk("ovf_flag", a_ovf, 1);
        chk("ovf_fill", a_fill, 2);
        for (int i = 0; i < 8; i++) begin
            rd_a(2*ad1[i]);
            rd_a(2*ad1[i] + 1);
        end
        rel_a();
        chk("src_rdy_after_rel", a_src_rdy, 1);
        for (int i = 0; i < 8; i++) begin
            rd_a(2*ad2[i]);
            rd_a(2*ad2[i] + 1);
        end
        rel_a();

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) wr_a(i, {$urandom, $urandom}, i == 3);
        rd_a(0);
        rd_a(3);
        a_exec = 1; a_ia = 10'd5;
        @(posedge clk);
        #3;
        a_rst_n = 0;
        #1;
        chk("arst_fill", a_fill, 0);
        chk("arst_rd_rdy", a_rd_rdy, 0);
        chk("arst_src_rdy", a_src_rdy, 1);
        chk("arst_d", a_d, 0);
        chk("arst_dv", a_d_v, 0);
        chk("arst_ovf", a_ovf, 0);
        a_wb = 0; a_rb = 0; a_fc = 0;
        a_exec = 0;
        tick();
        a_rst_n = 1;
        tick();
        chk("post_rst_rd_rdy", a_rd_rdy, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("recommit_rd_rdy_low", a_rd_rdy, 0);
            wr_a(i + 20, {$urandom, $urandom}, i == 3);
        end
        chk("recommit_rd_rdy", a_rd_rdy, 1);
        rd_a(40);
        rd_a(47);

        // Round-to-nearest-even vectors in bank0, random bank1
        for (int k = 0; k < 5; k++) wr_b(k, {$urandom, vec[k]}, k == 4);
        for (int i = 0; i < 4; i++) wr_b(i, {$urandom, $urandom}, i == 3);
        chk("b_fill2", b_fill, 2);
        for (int k = 0; k < 5; k++) begin
            rd_b(2*k);
            chk("b_rnd", b_d, vexp[k]);
            rd_b(2*k + 1);
        end

        // Commit, release and read on the same edge
        sd = {$urandom, $urandom};
        b_src_v = 1; b_src_a = 4'd0; b_src_d = sd; b_src_last = 1;
        b_rd_done = 1; b_exec = 1; b_ia = 5'd0;
        tick();
        b_src_v = 0; b_src_last = 0; b_rd_done = 0; b_exec = 0;
        chk("sim_dv", b_d_v, 1);
        chk("sim_old_bank", b_d, mb[b_rb][0]);
        chk("sim_old_const", b_d, 16'h3F80);
        chk("sim_fill", b_fill, 2);
        mb[b_wb][0] = ref_bf16(sd[31:0], 1);
        mb[b_wb][1] = ref_bf16(sd[63:32], 1);
        b_wb = (b_wb + 1) % 4;
        b_rb = (b_rb + 1) % 4;
        wr_b(5, {$urandom, $urandom}, 1'b1);
        chk("b_fill3", b_fill, 3);
        for (int i = 0; i < 8; i++) rd_b(i);
        rel_b();
        rd_b(0);
        rd_b(1);
        rel_b();
        rd_b(10);
        rd_b(11);
        rel_b();
        chk("b_rd_rdy_end", b_rd_rdy, 0);
        chk("b_ovf_end", b_ovf, 0);
        for (int i = 0; i < 4; i++) ad3[i] = i;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/src_ring_buf.md
# src_ring_buf

Parametrised multi-bank source buffer for the bf16 convolution engine. It sits between the host DMA port and the MAC array. The host writes words of packed fp32 lanes, which the block converts to bf16 and stores in a ring of BANKS independent banks. The array reads single bf16 operands from the oldest committed bank. Bank ownership moves between writer and reader through an explicit commit/release protocol with full/empty flow control.

## Interface
- BANKS, 2: bank count; power of two, ≥2.
- DEPTH, 512: words per bank; power of two.
- LANES, 2: fp32 lanes per host word; power of two; stored word is 16·LANES bits.
- RND, 0: fp32→bf16 conversion; 0 = truncate, 1 = round-to-nearest-even.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_v  in  1  host write strobe.
- src_a  in  log2(DEPTH)  word index within current write bank.
- src_d  in  32·LANES  fp32 lanes; lane k = src_d[32k+31:32k].
- src_last  in  1  with src_v: commit current write bank after this write.
- src_rdy  out  1  write bank available (fill_cnt < BANKS).
- exec  in  1  array read strobe.
- ia  in  log2(DEPTH·LANES)  operand index within current read bank.
- rd_done  in  1  release current read bank.
- rd_rdy  out  1  committed bank available (fill_cnt > 0).
- d  out  16  bf16 operand.
- d_v  out  1  d valid this cycle.
- fill_cnt  out  log2(BANKS)+1  committed-bank count.
- err_ovf  out  1  sticky: write or commit attempted while !src_rdy.
- err_udf  out  1  sticky: exec or rd_done attempted while !rd_rdy.

## Operation
- State: wr_bank, rd_bank (log2(BANKS) bits, wrap modulo BANKS), fill_cnt. Memory is one array per bank, single write port and single read port; memory contents are not reset.
- Write, accepted when src_v & src_rdy: mem[wr_bank][src_a] ← packed bf16; lane k goes to bits [16k+15:16k].
- Commit: src_v & src_rdy & src_last writes the word, then wr_bank+1 and fill_cnt+1.
- Conversion, per lane f:
  - RND=0: f[31:16].
  - RND=1: f[31:16] + (f[15] & (f[16] | |f[14:0])). Carry into the exponent is permitted, so a max-finite value rounds to ±Inf.
  - Any RND, if f[30:23]==8'hFF: result is f[31:16] with bit 6 forced to 1 if f[22:0]≠0, so a NaN stays NaN.
- Read, accepted when exec & rd_rdy: word = mem[rd_bank][ia >> log2(LANES)]; lane = ia[log2(LANES)-1:0] is registered with the read. Next cycle, d = selected lane and d_v = 1.
- Release, accepted when rd_done & rd_rdy: rd_bank+1, fill_cnt−1. A read accepted in the same cycle uses the old rd_bank.
- Commit and release in the same cycle: fill_cnt unchanged, both pointers advance.
- Rejected ops leave all state unchanged and set the matching sticky error:
  - src_v when !src_rdy sets err_ovf; the data is dropped.
  - exec or rd_done when !rd_rdy sets err_udf.
- Writer and reader always target different banks whenever both are enabled, so there are no port conflicts.
- Reset values: wr_bank=rd_bank=0, fill_cnt=0, src_rdy=1, rd_rdy=0, d=16'h0, d_v=0, err_ovf=err_udf=0. Reset mid-operation discards all committed banks; stale data is unreadable until recommitted.

## Timing
- Write to memory: 1 cycle.
- Commit visible to the reader: rd_rdy rises the cycle after the commit edge.
- Read latency: exec at edge t gives d/d_v valid during cycle t+1. Reads are fully pipelined at 1 operand per cycle.
- d holds its last value when d_v=0.
- src_rdy, rd_rdy and fill_cnt are registered, or decoded from registered fill_cnt only. No combinational path from inputs to outputs.
- Full (fill_cnt=BANKS): src_rdy=0; a release in cycle t gives src_rdy=1 at t+1.
- Empty: rd_rdy=0.

## Test plan
- Fill and drain, BANKS=2, LANES=2, RND=0:
  - Write words 0..511 to bank0 with src_last on 511, each word {32'h3F80_1234, 32'h4000_8000}.
  - Then exec ia=0..1023 and rd_done.
  - Required: ia=0 → 16'h4000, ia=1 → 16'h3F80, d_v exactly 1 cycle after each exec; fill_cnt goes 1 then 0.
- Rounding, RND=1:
  - lane 32'h3F80_8000 → 16'h3F80 (tie, even).
  - 32'h3F81_8000 → 16'h3F82.
  - 32'h7F7F_FFFF → 16'h7F80.
  - 32'h7F80_0001 → 16'h7FC0.
  - 32'h3F80_8001 → 16'h3F81.
- Full backpressure, BANKS=2:
  - Commit 2 banks; src_rdy=0; write attempt sets err_ovf=1 and memory is unchanged.
  - rd_done → src_rdy=1 next cycle.
- Simultaneous events, BANKS=4:
  - Start with fill_cnt=2; apply commit and release on the same edge.
  - Required: fill_cnt stays 2, wr_bank=3, rd_bank=1. The read in the release cycle returns data from the old bank.
- Underflow: exec and rd_done with fill_cnt=0 → err_udf=1, d_v stays 0, rd_bank stays 0.
- Async reset: drop rst_n mid-drain, between clock edges.
  - Required: immediately fill_cnt=0, rd_rdy=0, src_rdy=1, d=0, d_v=0.
  - After release, bank0 must be rewritten and committed before rd_rdy rises.
